// File: rtl/uart_fifo_tx_engine.sv
// UART transmit engine: pops a first-word-fall-through byte FIFO and serialises 8N1 frames
// using an internal 16x baud tick. Define UART_TX_PARITY_EN to insert an even parity bit (8E1).
module uart_fifo_tx_engine #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD_RATE = 9600,
    parameter int STOP_BITS = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        fifo_empty,
    input  logic [7:0]  fifo_rdata,
    output logic        fifo_rd,
    output logic        tx,
    output logic        busy,
    output logic        tx_done,
    output logic [15:0] frame_cnt
);

    localparam int BAUD_DIV   = CLK_FREQ / BAUD_RATE / 16;
    localparam int BAUD_COUNT = (BAUD_DIV < 1) ? 1 : BAUD_DIV;
    localparam int BAUD_W     = $clog2(BAUD_COUNT + 1);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_COUNT - 1);
    localparam logic [2:0]        STOP_LAST = 3'(STOP_BITS - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t              state_q, state_d;
    logic [BAUD_W-1:0]   baud_cnt_q, baud_cnt_d;
    logic [3:0]          os_cnt_q, os_cnt_d;
    logic [2:0]          bit_cnt_q, bit_cnt_d;
    logic [7:0]          shift_q, shift_d;
    logic                tx_q, tx_d;
    logic                busy_q, busy_d;
    logic                tx_done_q, tx_done_d;
    logic [15:0]         frame_cnt_q, frame_cnt_d;
`ifdef UART_TX_PARITY_EN
    logic                parity_q, parity_d;
`endif

    logic tick;
    logic bit_end;
    logic pop;

    // The tick counter only runs inside a frame, so every frame starts phase-aligned.
    assign tick    = (state_q != IDLE) && (baud_cnt_q == BAUD_LAST);
    assign bit_end = tick && (os_cnt_q == 4'hF);
    // Gated by reset so a byte is never lost from the FIFO while the engine is held.
    assign pop     = (state_q == IDLE) && enable && !fifo_empty && !reset;

    assign fifo_rd   = pop;
    assign tx        = tx_q;
    assign busy      = busy_q;
    assign tx_done   = tx_done_q;
    assign frame_cnt = frame_cnt_q;

    always_comb begin
        // NOTE: every variable gets a default first so no path through the case infers a latch.
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        tx_d        = tx_q;
        busy_d      = busy_q;
        tx_done_d   = 1'b0;
        frame_cnt_d = frame_cnt_q;
`ifdef UART_TX_PARITY_EN
        parity_d    = parity_q;
`endif

        if (state_q == IDLE || tick) begin
            baud_cnt_d = '0;
        end else begin
            baud_cnt_d = baud_cnt_q + BAUD_W'(1);
        end

        if (state_q == IDLE) begin
            os_cnt_d = 4'd0;
        end else if (tick) begin
            os_cnt_d = os_cnt_q + 4'd1;
        end else begin
            os_cnt_d = os_cnt_q;
        end

        case (state_q)
            IDLE: begin
                tx_d      = 1'b1;
                busy_d    = 1'b0;
                bit_cnt_d = 3'd0;
                if (pop) begin
                    shift_d = fifo_rdata;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^fifo_rdata;
`endif
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    tx_d      = shift_q[0];
                    bit_cnt_d = 3'd0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_cnt_q == 3'd7) begin
                        bit_cnt_d = 3'd0;
`ifdef UART_TX_PARITY_EN
                        tx_d    = parity_q;
                        state_d = PARITY;
`else
                        tx_d    = 1'b1;
                        state_d = STOP;
`endif
                    end else begin
                        tx_d      = shift_q[1];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    tx_d    = 1'b1;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    if (bit_cnt_q == STOP_LAST) begin
                        tx_done_d   = 1'b1;
                        frame_cnt_d = frame_cnt_q + 16'd1;
                        busy_d      = 1'b0;
                        bit_cnt_d   = 3'd0;
                        state_d     = IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            default: begin
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: non-blocking assignments here so every flop samples pre-edge values in parallel.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            baud_cnt_q  <= '0;
            os_cnt_q    <= 4'd0;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'd0;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
            tx_done_q   <= 1'b0;
            frame_cnt_q <= 16'd0;
`ifdef UART_TX_PARITY_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            baud_cnt_q  <= baud_cnt_d;
            os_cnt_q    <= os_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            tx_q        <= tx_d;
            busy_q      <= busy_d;
            tx_done_q   <= tx_done_d;
            frame_cnt_q <= frame_cnt_d;
`ifdef UART_TX_PARITY_EN
            parity_q    <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_fifo_tx_engine.sv
// Directed bench for uart_fifo_tx_engine: one bit = 16 clks (BAUD_COUNT=1), FIFO modelled locally,
// plus a STOP_BITS=2 instance. Parity frames are checked when UART_TX_PARITY_EN is defined.
`timescale 1ns/1ps
module tb_uart_fifo_tx_engine;

    localparam int CLK_FREQ  = 1_600_000;
    localparam int BAUD_RATE = 100_000;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    logic        clk    = 1'b0;
    logic        reset  = 1'b1;
    logic        enable = 1'b0;
    logic        fifo_empty, fifo_rd, tx, busy, tx_done;
    logic [7:0]  fifo_rdata;
    logic [15:0] frame_cnt;

    logic        fifo2_empty, fifo2_rd, tx2, busy2, tx_done2;
    logic [7:0]  fifo2_rdata = 8'hC3;
    logic [15:0] frame_cnt2;
    int          pushed2 = 0;
    int          popped2 = 0;

    logic [7:0]  mem [0:15];
    logic [3:0]  head = 4'd0;
    logic [3:0]  tail = 4'd0;

    int cyc = 0, last_pop_cyc = 0, pop_cnt = 0, done_cnt = 0, bad_rd = 0;
    int n_pass = 0, n_fail = 0, n_total = 0;

    always #5 clk = ~clk;

    assign fifo_empty  = (head == tail);
    assign fifo_rdata  = mem[head];
    assign fifo2_empty = (pushed2 == popped2);

    uart_fifo_tx_engine #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .STOP_BITS(1)) u0 (
        .clk(clk), .reset(reset), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_rdata(fifo_rdata), .fifo_rd(fifo_rd), .tx(tx), .busy(busy),
        .tx_done(tx_done), .frame_cnt(frame_cnt)
    );

    uart_fifo_tx_engine #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .STOP_BITS(2)) u2 (
        .clk(clk), .reset(reset), .enable(enable), .fifo_empty(fifo2_empty),
        .fifo_rdata(fifo2_rdata), .fifo_rd(fifo2_rd), .tx(tx2), .busy(busy2),
        .tx_done(tx_done2), .frame_cnt(frame_cnt2)
    );

    // FIFO model and event counters, all updated on the active edge.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_rd) begin
            last_pop_cyc <= cyc;
            head         <= head + 4'd1;
            pop_cnt      <= pop_cnt + 1;
            if (fifo_empty) bad_rd <= bad_rd + 1;
        end
        if (tx_done)  done_cnt <= done_cnt + 1;
        if (fifo2_rd) popped2  <= popped2 + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        mem[tail] = b;
        tail      = tail + 4'd1;
    endtask

    task automatic wait_start(input string tag);
        int n = 0;
        while (tx !== 1'b0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check({tag, " start_seen"}, 32'(tx), 32'(0));
    endtask

    // Called at the first negedge of the start bit; returns at the negedge after the last stop clk.
    task automatic check_frame(input string tag, input logic [7:0] b, input int drop_at);
        logic [FRAME_BITS-1:0] exp_bits;
        logic [15:0]           samp;
        logic                  busy_all;
        int                    c;
`ifdef UART_TX_PARITY_EN
        exp_bits = {1'b1, ^b, b, 1'b0};
`else
        exp_bits = {1'b1, b, 1'b0};
`endif
        check({tag, " latency"}, 32'(cyc), 32'(last_pop_cyc + 1));
        busy_all = 1'b1;
        c        = 0;
        for (int i = 0; i < FRAME_BITS; i++) begin
            for (int j = 0; j < 16; j++) begin
                if (c == drop_at) enable = 1'b0;
                samp[j]  = tx;
                busy_all = busy_all & busy;
                c++;
                @(negedge clk);
            end
            check($sformatf("%s bit%0d", tag, i), 32'(samp), 32'({16{exp_bits[i]}}));
        end
        check({tag, " busy_in_frame"}, 32'(busy_all), 32'(1));
        check({tag, " tx_done"}, 32'(tx_done), 32'(1));
        check({tag, " busy_gap"}, 32'(busy), 32'(0));
        check({tag, " tx_gap"}, 32'(tx), 32'(1));
    endtask

    initial begin
        int lows;
        int d0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst tx", 32'(tx), 32'(1));
        check("rst busy", 32'(busy), 32'(0));
        check("rst tx_done", 32'(tx_done), 32'(0));
        check("rst frame_cnt", 32'(frame_cnt), 32'(0));
        check("rst fifo_rd", 32'(fifo_rd), 32'(0));
        check("rst tx2", 32'(tx2), 32'(1));
        reset  = 1'b0;
        enable = 1'b1;

        // Empty FIFO: no pops, line idle for 1000 clks
        lows = 0;
        repeat (1000) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        check("empty tx_low_cycles", 32'(lows), 32'(0));
        check("empty pops", 32'(pop_cnt), 32'(0));

        // Single byte 0xA5: tx 0,1,0,1,0,0,1,0,1,1
        push(8'hA5);
        wait_start("a5");
        check_frame("a5", 8'hA5, -1);
        check("a5 frame_cnt", 32'(frame_cnt), 32'(1));
        check("a5 pops", 32'(pop_cnt), 32'(1));
        @(negedge clk);
        check("a5 tx_done_pulse_end", 32'(tx_done), 32'(0));
        check("a5 done_cnt", 32'(done_cnt), 32'(1));

        // Back-to-back 0x00, 0xFF, 0x3C: the gap cycle pops the next byte
        push(8'h00);
        push(8'hFF);
        push(8'h3C);
        wait_start("b2b0");
        check_frame("b2b0", 8'h00, -1);
        check("b2b0 gap_pop", 32'(fifo_rd), 32'(1));
        wait_start("b2b1");
        check_frame("b2b1", 8'hFF, -1);
        check("b2b1 gap_pop", 32'(fifo_rd), 32'(1));
        wait_start("b2b2");
        check_frame("b2b2", 8'h3C, -1);
        check("b2b2 no_pop", 32'(fifo_rd), 32'(0));
        check("b2b frame_cnt", 32'(frame_cnt), 32'(4));
        check("b2b pops", 32'(pop_cnt), 32'(4));

        // Drop enable at data bit 3 (clk 64 of the frame): frame completes, no second pop
        push(8'h55);
        push(8'h55);
        wait_start("endrop");
        check_frame("endrop", 8'h55, 64);
        check("endrop no_pop", 32'(fifo_rd), 32'(0));
        check("endrop frame_cnt", 32'(frame_cnt), 32'(5));
        lows = 0;
        repeat (200) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        check("endrop idle_low_cycles", 32'(lows), 32'(0));
        check("endrop pops", 32'(pop_cnt), 32'(5));
        enable = 1'b1;
        wait_start("reen");
        check_frame("reen", 8'h55, -1);
        check("reen frame_cnt", 32'(frame_cnt), 32'(6));

        // Reset during data bit 4 of 0x81 (clk 85 of the frame), then 0x5A goes out cleanly
        push(8'h81);
        push(8'h5A);
        wait_start("rst81");
        repeat (85) @(negedge clk);
        check("rst81 in_bit4", 32'(tx), 32'(0));
        reset = 1'b1;
        @(negedge clk);
        check("rst81 tx", 32'(tx), 32'(1));
        check("rst81 busy", 32'(busy), 32'(0));
        check("rst81 frame_cnt", 32'(frame_cnt), 32'(0));
        check("rst81 tx_done", 32'(tx_done), 32'(0));
        check("rst81 fifo_rd", 32'(fifo_rd), 32'(0));
        d0    = done_cnt;
        reset = 1'b0;
        wait_start("post_rst");
        check_frame("post_rst", 8'h5A, -1);
        check("post_rst frame_cnt", 32'(frame_cnt), 32'(1));
        @(negedge clk);
        check("post_rst done_cnt", 32'(done_cnt), 32'(d0 + 1));
        check("post_rst pops", 32'(pop_cnt), 32'(8));

        // STOP_BITS=2: stop high lasts 32 clks, tx_done after the second stop bit
        pushed2 = 1;
        lows = 0;
        while (tx2 !== 1'b0 && lows < 500) begin
            @(negedge clk);
            lows++;
        end
        check("sb2 start_seen", 32'(tx2), 32'(0));
        repeat ((FRAME_BITS - 1) * 16) @(negedge clk);
        lows = 0;
        for (int j = 0; j < 32; j++) begin
            if (j == 16) check("sb2 no_early_done", 32'(tx_done2), 32'(0));
            if (tx2 !== 1'b1) lows++;
            @(negedge clk);
        end
        check("sb2 stop_low_cycles", 32'(lows), 32'(0));
        check("sb2 tx_done", 32'(tx_done2), 32'(1));
        check("sb2 busy_end", 32'(busy2), 32'(0));
        check("sb2 frame_cnt", 32'(frame_cnt2), 32'(1));

        // Frame counter wrap: preload 0xFFFF, one more frame -> 0x0000
        force u0.frame_cnt_q = 16'hFFFF;
        @(negedge clk);
        release u0.frame_cnt_q;
        @(negedge clk);
        check("wrap preload", 32'(frame_cnt), 32'hFFFF);
        push(8'h12);
        wait_start("wrap");
        check_frame("wrap", 8'h12, -1);
        check("wrap frame_cnt", 32'(frame_cnt), 32'(0));

`ifdef UART_TX_PARITY_EN
        // 0x07 -> parity 1, 0x03 -> parity 0; each frame is 176 clks
        push(8'h07);
        push(8'h03);
        wait_start("par07");
        check_frame("par07", 8'h07, -1);
        wait_start("par03");
        check_frame("par03", 8'h03, -1);
        check("par frame_cnt", 32'(frame_cnt), 32'(2));
`endif

        check("no_pop_when_empty", 32'(bad_rd), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
